sdc_block_server: RTL and testbench

//  Responder side of the core's sector interface (sdc_lba/sdc_rd/sdc_wr/sdc_busy/sdc_done/sdc_data_*/sdc_addr).

---
 rtl/sdc_block_server.sv | 231 +++++++++++++++++++++++
 tb/tb_sdc_block_server.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_block_server.sv
// Sector server between the core's per-lane sector interface and a byte-stream block backend.
// Arbitrates lanes, then streams one 512-byte sector into or out of the core's sector buffer.
module sdc_block_server #(
  parameter int unsigned SCSI_DEVS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SCSI_DEVS+1:0] sdc_image_mounted,
  input  logic [31:0]          sdc_lba,
  input  logic [SCSI_DEVS+1:0] sdc_rd,
  input  logic [SCSI_DEVS+1:0] sdc_wr,
  output logic                 sdc_busy,
  output logic                 sdc_done,
  output logic [7:0]           sdc_data_in,
  output logic                 sdc_data_en,
  output logic [8:0]           sdc_addr,
  input  logic [7:0]           sdc_data_out,
  output logic                 blk_req,
  output logic                 blk_wr,
  output logic [2:0]           blk_dev,
  output logic [31:0]          blk_lba,
  input  logic                 blk_ack,
  input  logic [7:0]           blk_rdata,
  input  logic                 blk_rvalid,
  output logic [7:0]           blk_wdata,
  output logic                 blk_wvalid,
  input  logic                 blk_wready,
  input  logic                 blk_done
);

  localparam int unsigned N     = SCSI_DEVS + 2;
  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(511);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_RD, S_WFETCH, S_WPRES, S_WEND, S_ZERO, S_DONE, S_REL
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [7:0]       r_data_in, w_data_in_nxt;
  logic             r_data_en, w_data_en_nxt;
  logic [8:0]       r_addr, w_addr_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_blk_req, w_blk_req_nxt;
  logic             r_blk_wr, w_blk_wr_nxt;
  logic [2:0]       r_blk_dev, w_blk_dev_nxt;
  logic [31:0]      r_blk_lba, w_blk_lba_nxt;
  logic [7:0]       r_wdata, w_wdata_nxt;
  logic             r_wvalid, w_wvalid_nxt;

  logic       w_hit, w_pick_rd, w_pick_mnt, w_lane_act;
  logic [2:0] w_pick_lane;

  // Lowest requesting lane wins; also track whether the latched lane still holds its request.
  always_comb begin
    w_hit       = 1'b0;
    w_pick_rd   = 1'b0;
    w_pick_mnt  = 1'b0;
    w_pick_lane = 3'd0;
    w_lane_act  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!w_hit && (sdc_rd[i] || sdc_wr[i])) begin
        w_hit       = 1'b1;
        w_pick_rd   = sdc_rd[i];
        w_pick_mnt  = sdc_image_mounted[i];
        w_pick_lane = 3'(i);
      end
      if (r_blk_dev == 3'(i)) begin
        w_lane_act = sdc_rd[i] || sdc_wr[i];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_data_in_nxt = r_data_in;
    w_data_en_nxt = 1'b0;
    w_addr_nxt    = r_addr;
    w_count_nxt   = r_count;
    w_blk_req_nxt = r_blk_req;
    w_blk_wr_nxt  = r_blk_wr;
    w_blk_dev_nxt = r_blk_dev;
    w_blk_lba_nxt = r_blk_lba;
    w_wdata_nxt   = r_wdata;
    w_wvalid_nxt  = r_wvalid;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_blk_dev_nxt = w_pick_lane;
          w_blk_wr_nxt  = !w_pick_rd;
          w_blk_lba_nxt = sdc_lba;
          w_busy_nxt    = 1'b1;
          w_count_nxt   = '0;
          // Address 0 is presented early so the first write byte is ready when fetching starts.
          w_addr_nxt    = 9'd0;
          if (w_pick_mnt) begin
            w_state_nxt   = S_REQ;
            w_blk_req_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ZERO;
          end
        end
      end
      S_REQ: begin
        if (blk_ack) begin
          w_blk_req_nxt = 1'b0;
          w_state_nxt   = r_blk_wr ? S_WFETCH : S_RD;
        end
      end
      S_RD: begin
        if (blk_rvalid && !r_count[9]) begin
          w_data_in_nxt = blk_rdata;
          w_data_en_nxt = 1'b1;
          w_addr_nxt    = r_count[8:0];
          w_count_nxt   = r_count + CNT_W'(1);
        end
        if (blk_done) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      S_WFETCH: begin
        if (blk_done) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt  = S_WPRES;
          w_wdata_nxt  = sdc_data_out;
          w_wvalid_nxt = 1'b1;
          // Prefetch the next buffer byte while this one is being handed to the backend.
          if (r_count != LAST_BYTE) begin
            w_addr_nxt = r_count[8:0] + 9'd1;
          end
        end
      end
      S_WPRES: begin
        if (blk_done) begin
          w_wvalid_nxt = 1'b0;
          w_state_nxt  = S_DONE;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
        end else if (blk_wready) begin
          w_wvalid_nxt = 1'b0;
          w_count_nxt  = r_count + CNT_W'(1);
          w_state_nxt  = (r_count == LAST_BYTE) ? S_WEND : S_WFETCH;
        end
      end
      S_WEND: begin
        if (blk_done) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      S_ZERO: begin
        if (!r_blk_wr && !r_count[9]) begin
          w_data_in_nxt = 8'h00;
          w_data_en_nxt = 1'b1;
          w_addr_nxt    = r_count[8:0];
          w_count_nxt   = r_count + CNT_W'(1);
        end else begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_REL;
      end
      S_REL: begin
        if (!w_lane_act) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_data_in <= 8'd0;
      r_data_en <= 1'b0;
      r_addr    <= 9'd0;
      r_count   <= '0;
      r_blk_req <= 1'b0;
      r_blk_wr  <= 1'b0;
      r_blk_dev <= 3'd0;
      r_blk_lba <= 32'd0;
      r_wdata   <= 8'd0;
      r_wvalid  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_data_in <= w_data_in_nxt;
      r_data_en <= w_data_en_nxt;
      r_addr    <= w_addr_nxt;
      r_count   <= w_count_nxt;
      r_blk_req <= w_blk_req_nxt;
      r_blk_wr  <= w_blk_wr_nxt;
      r_blk_dev <= w_blk_dev_nxt;
      r_blk_lba <= w_blk_lba_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wvalid  <= w_wvalid_nxt;
    end
  end

  assign sdc_busy    = r_busy;
  assign sdc_done    = r_done;
  assign sdc_data_in = r_data_in;
  assign sdc_data_en = r_data_en;
  assign sdc_addr    = r_addr;
  assign blk_req     = r_blk_req;
  assign blk_wr      = r_blk_wr;
  assign blk_dev     = r_blk_dev;
  assign blk_lba     = r_blk_lba;
  assign blk_wdata   = r_wdata;
  assign blk_wvalid  = r_wvalid;

endmodule

// File: tb/tb_sdc_block_server.sv
// Directed bench for sdc_block_server: a core-buffer model, a byte-stream backend driven from
// the main sequence, and scoreboards for buffer strobes and backend write bytes.
module tb_sdc_block_server;

  localparam int unsigned SCSI_DEVS = 2;
  localparam int unsigned N = SCSI_DEVS + 2;

  logic         clk;
  logic         reset;
  logic [N-1:0] sdc_image_mounted;
  logic [31:0]  sdc_lba;
  logic [N-1:0] sdc_rd;
  logic [N-1:0] sdc_wr;
  logic         sdc_busy;
  logic         sdc_done;
  logic [7:0]   sdc_data_in;
  logic         sdc_data_en;
  logic [8:0]   sdc_addr;
  logic [7:0]   sdc_data_out;
  logic         blk_req;
  logic         blk_wr;
  logic [2:0]   blk_dev;
  logic [31:0]  blk_lba;
  logic         blk_ack;
  logic [7:0]   blk_rdata;
  logic         blk_rvalid;
  logic [7:0]   blk_wdata;
  logic         blk_wvalid;
  logic         blk_wready;
  logic         blk_done;

  sdc_block_server #(.SCSI_DEVS(SCSI_DEVS)) dut (
    .clk(clk), .reset(reset),
    .sdc_image_mounted(sdc_image_mounted), .sdc_lba(sdc_lba),
    .sdc_rd(sdc_rd), .sdc_wr(sdc_wr),
    .sdc_busy(sdc_busy), .sdc_done(sdc_done),
    .sdc_data_in(sdc_data_in), .sdc_data_en(sdc_data_en), .sdc_addr(sdc_addr),
    .sdc_data_out(sdc_data_out),
    .blk_req(blk_req), .blk_wr(blk_wr), .blk_dev(blk_dev), .blk_lba(blk_lba),
    .blk_ack(blk_ack), .blk_rdata(blk_rdata), .blk_rvalid(blk_rvalid),
    .blk_wdata(blk_wdata), .blk_wvalid(blk_wvalid), .blk_wready(blk_wready),
    .blk_done(blk_done)
  );

  int checks   = 0;
  int errors   = 0;
  int n_strobe = 0;
  int n_done   = 0;
  int n_req    = 0;

  logic [16:0] sq[$];   // expected {addr, data} buffer strobes
  logic [7:0]  wq[$];   // expected backend write bytes
  logic [7:0]  core_buf [512];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core sector buffer read port: one cycle registered latency.
  always @(posedge clk) sdc_data_out <= core_buf[sdc_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the strobe scoreboard and counts done pulses / request cycles.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!reset) begin
      if (sdc_data_en) begin
        n_strobe++;
        if (sq.size() == 0) begin
          chk("strobe_unexpected", 32'(sdc_addr), 32'hFFFF_FFFF);
        end else begin
          e = sq.pop_front();
          chk("strobe", 32'({sdc_addr, sdc_data_in}), 32'(e));
        end
      end
      if (sdc_done) n_done++;
      if (blk_req) n_req++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!blk_req && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(blk_req), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!sdc_done && k < 3000) begin
      tick();
      k++;
    end
    chk(tag, 32'(sdc_done), 32'd1);
    chk({tag, "_busy"}, 32'(sdc_busy), 32'd0);
  endtask

  // Acknowledge, stream nbytes (plus extra ignored bytes) and signal sector completion.
  task automatic serve_read(input int nbytes, input int extra, input logic [7:0] off);
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
    chk("req_fall", 32'(blk_req), 32'd0);
    for (int i = 0; i < nbytes; i++) begin
      blk_rvalid = 1'b1;
      blk_rdata  = 8'(i) + off;
      sq.push_back({9'(i), 8'(i) + off});
      tick();
    end
    for (int i = 0; i < extra; i++) begin
      blk_rvalid = 1'b1;
      blk_rdata  = 8'hEE;
      tick();
    end
    blk_rvalid = 1'b0;
    blk_done   = 1'b1;
    tick();
    blk_done   = 1'b0;
  endtask

  // Acknowledge and consume 512 write bytes, then check the sector waits on blk_done.
  task automatic serve_write(input bit toggle);
    int k   = 0;
    int cyc = 0;
    logic rdy;
    logic [7:0] e;
    for (int i = 0; i < 512; i++) wq.push_back(~8'(i));
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
    while (k < 512 && cyc < 6000) begin
      rdy = toggle ? 1'(cyc % 2) : 1'b1;
      blk_wready = rdy;
      if (blk_wvalid && rdy) begin
        e = wq.pop_front();
        chk("wdata", 32'(blk_wdata), 32'(e));
        k++;
      end
      tick();
      cyc++;
    end
    blk_wready = 1'b0;
    chk("wbytes", 32'(k), 32'd512);
    tick();
    tick();
    chk("wend_no_done", 32'(sdc_done), 32'd0);
    chk("wend_busy", 32'(sdc_busy), 32'd1);
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, d0, r0;
    bit held_ok;
    for (int i = 0; i < 512; i++) core_buf[i] = ~8'(i);
    reset = 1'b1;
    sdc_image_mounted = 4'b1111;
    sdc_lba = 32'd0;
    sdc_rd = '0;
    sdc_wr = '0;
    blk_ack = 1'b0;
    blk_rdata = 8'd0;
    blk_rvalid = 1'b0;
    blk_wready = 1'b0;
    blk_done = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(sdc_busy), 32'd0);
    chk("rst_done", 32'(sdc_done), 32'd0);
    chk("rst_en", 32'(sdc_data_en), 32'd0);
    chk("rst_addr", 32'(sdc_addr), 32'd0);
    chk("rst_req", 32'(blk_req), 32'd0);
    chk("rst_wvalid", 32'(blk_wvalid), 32'd0);
    reset = 1'b0;
    tick();

    // Read lane 2, full sector plus two stray bytes
    s0 = n_strobe; d0 = n_done;
    sdc_lba = 32'h1234;
    sdc_rd  = 4'b0100;
    tick();
    chk("t1_busy", 32'(sdc_busy), 32'd1);
    chk("t1_req", 32'(blk_req), 32'd1);
    chk("t1_dev", 32'(blk_dev), 32'd2);
    chk("t1_dir", 32'(blk_wr), 32'd0);
    chk("t1_lba", blk_lba, 32'h1234);
    sdc_lba = 32'hDEAD;
    tick();
    chk("t1_req_held", 32'(blk_req), 32'd1);
    serve_read(512, 2, 8'h00);
    wait_done("t1_done");
    chk("t1_lba_kept", blk_lba, 32'h1234);
    tick();
    chk("t1_done_pulse", 32'(sdc_done), 32'd0);
    chk("t1_strobes", 32'(n_strobe - s0), 32'd512);
    chk("t1_dones", 32'(n_done - d0), 32'd1);
    chk("t1_sq_empty", 32'(sq.size()), 32'd0);
    sdc_rd = '0;
    tick();
    tick();

    // Lane 0 read and lane 3 write requested together
    sdc_lba = 32'h77;
    sdc_rd  = 4'b0001;
    sdc_wr  = 4'b1000;
    wait_req("t2_req0");
    chk("t2_dev0", 32'(blk_dev), 32'd0);
    chk("t2_dir0", 32'(blk_wr), 32'd0);
    serve_read(512, 0, 8'h40);
    wait_done("t2_done0");
    r0 = n_req;
    repeat (5) tick();
    chk("t2_lane3_waits", 32'(n_req - r0), 32'd0);
    sdc_rd = '0;
    wait_req("t2_req3");
    chk("t2_dev3", 32'(blk_dev), 32'd3);
    chk("t2_dir3", 32'(blk_wr), 32'd1);
    s0 = n_strobe;
    serve_write(1'b0);
    wait_done("t2_done3");
    chk("t2_no_strobes", 32'(n_strobe - s0), 32'd0);
    sdc_wr = '0;
    tick();
    tick();

    // Write lane 1 with wready toggling
    s0 = n_strobe;
    sdc_wr = 4'b0010;
    wait_req("t3_req");
    chk("t3_dev", 32'(blk_dev), 32'd1);
    chk("t3_dir", 32'(blk_wr), 32'd1);
    serve_write(1'b1);
    wait_done("t3_done");
    chk("t3_no_strobes", 32'(n_strobe - s0), 32'd0);
    chk("t3_wq_empty", 32'(wq.size()), 32'd0);
    sdc_wr = '0;
    tick();
    tick();

    // Read on unmounted lane 3 returns a zero sector without touching the backend
    sdc_image_mounted = 4'b0111;
    s0 = n_strobe; r0 = n_req;
    for (int i = 0; i < 512; i++) sq.push_back({9'(i), 8'h00});
    sdc_rd = 4'b1000;
    tick();
    chk("t4_busy", 32'(sdc_busy), 32'd1);
    wait_done("t4_done");
    chk("t4_no_req", 32'(n_req - r0), 32'd0);
    chk("t4_strobes", 32'(n_strobe - s0), 32'd512);
    sdc_rd = '0;
    tick();
    tick();
    chk("t4_busy_after", 32'(sdc_busy), 32'd0);

    // Reset in the middle of a read, then a fresh read from address 0
    d0 = n_done;
    sdc_rd = 4'b0100;
    wait_req("t5_req");
    blk_ack = 1'b1;
    tick();
    blk_ack = 1'b0;
    for (int i = 0; i < 200; i++) begin
      blk_rvalid = 1'b1;
      blk_rdata  = 8'(i);
      sq.push_back({9'(i), 8'(i)});
      tick();
    end
    blk_rdata = 8'd200;
    reset = 1'b1;
    tick();
    blk_rvalid = 1'b0;
    chk("t5_busy", 32'(sdc_busy), 32'd0);
    chk("t5_req", 32'(blk_req), 32'd0);
    chk("t5_en", 32'(sdc_data_en), 32'd0);
    chk("t5_sq_empty", 32'(sq.size()), 32'd0);
    reset = 1'b0;
    sdc_rd = '0;
    repeat (3) tick();
    chk("t5_no_done", 32'(n_done - d0), 32'd0);
    s0 = n_strobe;
    sdc_lba = 32'h55;
    sdc_rd = 4'b0100;
    wait_req("t5_req2");
    chk("t5_lba2", blk_lba, 32'h55);
    serve_read(512, 0, 8'h03);
    wait_done("t5_done2");
    chk("t5_strobes2", 32'(n_strobe - s0), 32'd512);

    // Held read level is not re-served; a new rising request is
    r0 = n_req;
    held_ok = 1'b1;
    repeat (6) begin
      tick();
      if (sdc_busy) held_ok = 1'b0;
    end
    chk("t6_no_reserve", 32'(n_req - r0), 32'd0);
    chk("t6_idle_busy", 32'(held_ok), 32'd1);
    sdc_rd = '0;
    tick();
    tick();
    s0 = n_strobe;
    sdc_rd = 4'b0100;
    wait_req("t6_req");
    chk("t6_dev", 32'(blk_dev), 32'd2);
    serve_read(3, 0, 8'h90);
    wait_done("t6_done");
    chk("t6_short_strobes", 32'(n_strobe - s0), 32'd3);
    sdc_rd = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
